alu_arbiter: RTL and testbench

- Shares one 4-bit ALU instance between two requesters.
- Accepts operation requests over a valid/ready handshake and arbitrates round-robin.
- Drives the ALU operand and operator inputs from registers, captures its result and CCR flags, and returns them to the winning requester over a response handshake.
- Sits between the ALU and the two client blocks that issue arithmetic/logic operations.

---
 rtl/alu_arbiter_if.sv | 51 +++++
 rtl/alu_arbiter.sv | 96 +++++++++
 tb/tb_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signals of the two-client ALU arbiter.
// No logic here; latency is defined by alu_arbiter.
// Backpressure uses the valid/ready pairs carried in this bundle.
interface alu_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_x;
  logic [1:0]        rsp_ccr;
  logic [DATA_W-1:0] alu_n1;
  logic [DATA_W-1:0] alu_n2;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_x;
  logic [1:0]        alu_ccr;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_x, rsp_ccr,
    input  rsp0_ready, rsp1_ready,
    output alu_n1, alu_n2, alu_op,
    input  alu_x, alu_ccr
  );

  // Client/ALU side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_x, rsp_ccr,
    output rsp0_ready, rsp1_ready,
    input  alu_n1, alu_n2, alu_op,
    output alu_x, alu_ccr
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational 4-bit ALU between two requesters.
// Latency: accept -> rsp_valid in 2 cycles, 3 cycles minimum per transaction.
// Backpressure: holds the response until the owner's rsp_ready; no accepts outside IDLE.
module alu_arbiter #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic              busy,
  output logic              grant_id,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);

  logic [1:0] state;
  logic       last_grant;
  logic       win;
  logic       accept;
  logic       rsp_take;
  logic       arb_open;

  // Pick the winner: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    win = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      win = ~last_grant;
    end
  end

  // Ready only in IDLE and never while reset is held, so nothing is handshaken during reset
  assign arb_open       = (state == IDLE) && rst_n;
  assign bus.req0_ready = arb_open && bus.req0_valid && !win;
  assign bus.req1_ready = arb_open && bus.req1_valid && win;
  assign accept         = (state == IDLE) && (bus.req0_valid || bus.req1_valid);

  // Only the owner's response port is valid; the other rsp_ready is ignored
  assign bus.rsp0_valid = (state == RESP) && !grant_id;
  assign bus.rsp1_valid = (state == RESP) && grant_id;
  assign rsp_take       = grant_id ? bus.rsp1_ready : bus.rsp0_ready;
  assign busy           = (state != IDLE);

  // Transaction FSM: latch operands, capture ALU result, hold response until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      op_count    <= '0;
      bus.alu_n1  <= {DATA_W{1'b0}};
      bus.alu_n2  <= {DATA_W{1'b0}};
      bus.alu_op  <= {OP_W{1'b0}};
      bus.rsp_x   <= {DATA_W{1'b0}};
      bus.rsp_ccr <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.alu_op <= win ? bus.req1_op : bus.req0_op;
            bus.alu_n1 <= win ? bus.req1_a  : bus.req0_a;
            bus.alu_n2 <= win ? bus.req1_b  : bus.req0_b;
            grant_id   <= win;
            state      <= EXEC;
          end
        end
        EXEC: begin
          bus.rsp_x <= bus.alu_x;
          // Carry/overflow only mean something for add and sub
          if (bus.alu_op == OP_ADD || bus.alu_op == OP_SUB) begin
            bus.rsp_ccr <= bus.alu_ccr;
          end else begin
            bus.rsp_ccr <= 2'b00;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            last_grant <= grant_id;
            op_count   <= op_count + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 4-bit ALU.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// Exercises handshakes, flag masking, round-robin, backpressure, reset and counter wrap.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic       grant_id;
  logic [7:0] op_count;
  int         n_chk = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(4), .OP_W(3)) bus ();

  alu_arbiter #(.DATA_W(4), .OP_W(3), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .op_count (op_count)
  );

  // Behavioural ALU; non-arithmetic ops drive junk flags 11 so masking is visible
  logic [4:0] sum;
  always_comb begin
    sum         = 5'd0;
    bus.alu_x   = 4'd0;
    bus.alu_ccr = 2'b11;
    case (bus.alu_op)
      3'b000: begin
        sum         = {1'b0, bus.alu_n1} + {1'b0, bus.alu_n2};
        bus.alu_x   = sum[3:0];
        bus.alu_ccr = {sum[4], (bus.alu_n1[3] == bus.alu_n2[3]) && (sum[3] != bus.alu_n1[3])};
      end
      3'b001: begin
        sum         = {1'b0, bus.alu_n1} + {1'b0, ~bus.alu_n2} + 5'd1;
        bus.alu_x   = sum[3:0];
        bus.alu_ccr = {sum[4], (bus.alu_n1[3] != bus.alu_n2[3]) && (sum[3] != bus.alu_n1[3])};
      end
      3'b010:  bus.alu_x = bus.alu_n1 << 1;
      3'b011:  bus.alu_x = ~bus.alu_n1 + 4'd1;
      3'b100:  bus.alu_x = ~bus.alu_n1;
      3'b101:  bus.alu_x = bus.alu_n1 & bus.alu_n2;
      3'b110:  bus.alu_x = bus.alu_n1 | bus.alu_n2;
      default: bus.alu_x = bus.alu_n1 ^ bus.alu_n2;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drop_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_op = 3'd0; bus.req0_a = 4'd0; bus.req0_b = 4'd0;
    bus.req1_op = 3'd0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drop_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One transaction from a single requester with response ready held high
  task automatic run_txn(input logic who, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] ex, input logic [1:0] eccr);
    @(negedge clk);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    if (!who) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
    #1;
    chk("acc_rdy",   32'(who ? bus.req1_ready : bus.req0_ready), 1);
    chk("acc_other", 32'(who ? bus.req0_ready : bus.req1_ready), 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk("exec_n1",   32'(bus.alu_n1), 32'(a));
    chk("exec_n2",   32'(bus.alu_n2), 32'(b));
    chk("exec_op",   32'(bus.alu_op), 32'(op));
    chk("exec_busy", 32'(busy), 1);
    chk("exec_novld", 32'(bus.rsp0_valid | bus.rsp1_valid), 0);
    @(negedge clk);
    #1;
    chk("rsp_vld",   32'(who ? bus.rsp1_valid : bus.rsp0_valid), 1);
    chk("rsp_other", 32'(who ? bus.rsp0_valid : bus.rsp1_valid), 0);
    chk("rsp_x",     32'(bus.rsp_x), 32'(ex));
    chk("rsp_ccr",   32'(bus.rsp_ccr), 32'(eccr));
    chk("rsp_grant", 32'(grant_id), 32'(who));
    @(negedge clk);
    #1;
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    drop_inputs();
    // Reset state, with both requesters pushing to prove readies are held low
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rdy0",  32'(bus.req0_ready), 0);
    chk("rst_rdy1",  32'(bus.req1_ready), 0);
    chk("rst_rvld",  32'(bus.rsp0_valid | bus.rsp1_valid), 0);
    chk("rst_n1",    32'(bus.alu_n1), 0);
    chk("rst_op",    32'(bus.alu_op), 0);
    chk("rst_x",     32'(bus.rsp_x), 0);
    chk("rst_cnt",   32'(op_count), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy",  32'(busy), 0);
    drop_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single add: 7+1 = 8, signed overflow, no carry
    run_txn(1'b0, 3'b000, 4'b0111, 4'b0001, 4'b1000, 2'b01);
    chk("add_cnt", 32'(op_count), 1);

    // Logic op: flags from the ALU must be masked to 00
    run_txn(1'b1, 3'b101, 4'b1100, 4'b1010, 4'b1000, 2'b00);
    chk("and_cnt", 32'(op_count), 2);

    // Simultaneous requests from reset: grants alternate 0,1,0,1
    do_reset();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_op = 3'b000; bus.req1_a = 4'd3; bus.req1_b = 4'd3;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_win_rdy",  32'((k % 2) ? bus.req1_ready : bus.req0_ready), 1);
      chk("rr_lose_rdy", 32'((k % 2) ? bus.req0_ready : bus.req1_ready), 0);
      @(negedge clk);
      #1;
      chk("rr_exec_rdy", 32'(bus.req0_ready | bus.req1_ready), 0);
      @(negedge clk);
      #1;
      chk("rr_grant", 32'(grant_id), 32'(k % 2));
      chk("rr_rvld",  32'((k % 2) ? bus.rsp1_valid : bus.rsp0_valid), 1);
      chk("rr_x",     32'(bus.rsp_x), (k % 2) ? 6 : 2);
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk("rr_cnt",  32'(op_count), 4);
    chk("rr_busy", 32'(busy), 0);

    // Response backpressure: 7+9 = 0 with carry, held for 5 cycles
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 3'b000; bus.req0_a = 4'b0111; bus.req0_b = 4'b1001;
    #1;
    chk("bp_acc", 32'(bus.req0_ready), 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = 3'b110; bus.req1_a = 4'd2; bus.req1_b = 4'd4;
    #1;
    chk("bp_exec_rdy1", 32'(bus.req1_ready), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_rvld0", 32'(bus.rsp0_valid), 1);
      chk("bp_rvld1", 32'(bus.rsp1_valid), 0);
      chk("bp_x",     32'(bus.rsp_x), 0);
      chk("bp_ccr",   32'(bus.rsp_ccr), 2);
      chk("bp_busy",  32'(busy), 1);
      chk("bp_rdy1",  32'(bus.req1_ready), 0);
    end
    @(negedge clk);
    bus.rsp0_ready = 1'b1;
    #1;
    chk("bp_hs_vld",  32'(bus.rsp0_valid), 1);
    chk("bp_hs_rdy1", 32'(bus.req1_ready), 0);
    @(negedge clk);
    #1;
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_rdy1", 32'(bus.req1_ready), 1);
    chk("bp_cnt",       32'(op_count), 5);
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b0;

    // Reset during EXEC drops the transaction
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op = 3'b110; bus.req0_a = 4'd5; bus.req0_b = 4'd3;
    #1;
    chk("mr_acc", 32'(bus.req0_ready), 1);
    @(negedge clk);
    bus.req1_valid = 1'b1;
    #1;
    chk("mr_exec_n1", 32'(bus.alu_n1), 5);
    rst_n = 1'b0;
    #1;
    chk("mr_busy",  32'(busy), 0);
    chk("mr_rdy",   32'(bus.req0_ready | bus.req1_ready), 0);
    chk("mr_rvld",  32'(bus.rsp0_valid | bus.rsp1_valid), 0);
    chk("mr_n1",    32'(bus.alu_n1), 0);
    chk("mr_n2",    32'(bus.alu_n2), 0);
    chk("mr_op",    32'(bus.alu_op), 0);
    chk("mr_x",     32'(bus.rsp_x), 0);
    chk("mr_ccr",   32'(bus.rsp_ccr), 0);
    chk("mr_cnt",   32'(op_count), 0);
    chk("mr_grant", 32'(grant_id), 0);
    @(negedge clk);
    drop_inputs();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("mr_no_rsp", 32'(bus.rsp0_valid | bus.rsp1_valid), 0);
    end
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("mr_tie0", 32'(bus.req0_ready), 1);
    chk("mr_tie1", 32'(bus.req1_ready), 0);

    // Counter wrap: 256 back-to-back transactions, 3 cycles each, alternating owners
    bus.req0_op = 3'b000; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
    bus.req1_op = 3'b000; bus.req1_a = 4'd3; bus.req1_b = 4'd3;
    repeat (765) @(negedge clk);
    #1;
    chk("wrap_255", 32'(op_count), 255);
    repeat (3) @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk("wrap_0",     32'(op_count), 0);
    chk("wrap_busy",  32'(busy), 0);
    chk("wrap_grant", 32'(grant_id), 1);
    chk("wrap_x",     32'(bus.rsp_x), 6);
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("wrap_tie0", 32'(bus.req0_ready), 1);
    chk("wrap_tie1", 32'(bus.req1_ready), 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
